sseg_scan_driver: RTL
=====================

// Module: sseg_scan_driver
// PURPOSE
//  Downstream display stage for the calculator: multiplexes a 4-digit hex value onto a
//  common-anode 7-segment display (shared sseg_o, one-hot anodes). Uses a frame-synchronous
//  load handshake so a new value never tears mid-frame. Includes leading-zero blanking,
//  a decimal-point mask and an anti-ghosting blank gap at the start of each digit slot.
// PARAMETERS
//  SCAN_DIV   50000  clk cycles per digit slot; legal range >= 2
//  BLANK_CYC  16     cycles at the start of each slot with all anodes off; legal range < SCAN_DIV
//  SEG_ACT_LO 1      1: segments active-low; 0: segments active-high (whole sseg_o inverted)
//  AN_ACT_LO  1      1: anodes active-low; 0: anodes active-high
// PORTS
//  clk         in   1   system clock, rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  value_i     in   16  hex value; [3:0] = digit 0 (rightmost)
//  dp_i        in   4   decimal-point mask; bit n = digit n
//  load_i      in   1   one-cycle strobe; captures value_i/dp_i into the pending register
//  blank_lz_i  in   1   1 = blank leading zero digits
//  enable_i    in   1   0 = display dark (scanning continues)
//  load_ack_o  out  1   one-cycle pulse when pending data is committed to the display
//  sseg_o      out  8   {dp,g,f,e,d,c,b,a}, registered
//  anodes      out  4   digit select; bit n = digit n; registered
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - Prescaler = 0, idx = 0, display reg = 0, pending_v = 0, load_ack_o = 0.
//   - sseg_o = all segments off: 8'hFF when SEG_ACT_LO = 1.
//   - anodes = all digits off: 4'hF when AN_ACT_LO = 1.
//  Scan
//   - Prescaler counts 0..SCAN_DIV-1; tick = (prescaler == SCAN_DIV-1).
//   - On tick: idx <= idx + 1 mod 4. Order is 0,1,2,3,0,...; frame = 4*SCAN_DIV cycles.
//  Output timing
//   - Outputs are registered from {idx, prescaler}: 1-cycle latency.
//   - For the first BLANK_CYC cycles of a slot, anodes are all off.
//   - For the rest of the slot, only anodes[idx] is on.
//  Segment decode (active-low form)
//   - Standard hex table 0-F, e.g. 0=C0, 1=F9, 2=A4, 3=B0, 4=99 (dp bit7 = 1, i.e. off).
//   - dp segment is lit when dp_i_reg[idx] = 1.
//  Leading-zero blanking (blank_lz_i = 1)
//   - Digit n (n = 3..1) is blanked if it and all higher digits are 0.
//   - Digit 0 is never blanked.
//   - A blanked digit drives a, b, c, d, e, f, g off. dp still follows the mask.
//   - Its anode is still driven.
//  Enable
//   - enable_i = 0: anodes all off and sseg_o all off from the next cycle.
//   - Prescaler and idx keep running, so re-enable does not reset phase.
//  Load handshake
//   - load_i = 1: pending <= {value_i, dp_i}; pending_v <= 1.
//   - Repeated loads before commit overwrite the pending data (latest wins, no ack for dropped ones).
//   - Commit happens on a tick with idx == 3 (frame boundary) and pending_v = 1:
//     display <= pending; pending_v <= 0; load_ack_o = 1 for that single cycle.
//  Simultaneous load_i and commit in the same cycle
//   - The old pending content is committed and acked.
//   - The new data becomes pending, pending_v = 1, and it commits at the next frame boundary.
//  Reset mid-frame
//   - All state is cleared immediately (async). Any pending load is lost and no ack is issued.
//  Width
//   - The prescaler is $clog2(SCAN_DIV) bits and wraps only via compare, never via overflow.
// TESTING (bench uses SCAN_DIV = 8, BLANK_CYC = 2, active-low)
//  1. Reset held -> sseg_o = FF, anodes = F, load_ack_o = 0.
//     Release -> anodes walks E,D,B,7 with a 2-cycle F gap every 8 cycles.
//  2. load_i with 16'h1234, dp_i = 0 -> exactly one load_ack_o at the idx 3->0 tick.
//     Next frame: digit0 = 99, digit1 = B0, digit2 = A4, digit3 = F9.
//  3. value 16'h0007, blank_lz_i = 1 -> digits 3..1 show FF, digit 0 shows F8.
//     With blank_lz_i = 0 -> digits 3..1 show C0.
//  4. Load 16'hAAAA then 16'h5555 within one frame -> a single ack; 5555 is displayed.
//     Load coinciding with the commit tick -> two acks, one frame apart.
//  5. dp_i = 4'b0100 -> only digit 2 has bit7 = 0.
//     enable_i = 0 mid-slot -> next cycle anodes = F, sseg_o = FF.
//     Re-enable -> scan phase is unchanged.
//  6. Assert rst_n low mid-slot with a pending load -> outputs go to FF/F asynchronously.
//     No ack follows; after release the display shows 0000.

Source files
------------

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: multiplexes a 4-digit hex value onto a common-anode 7-segment display.
// The scan walks digits 0..3, one slot of SCAN_DIV cycles each. Every slot opens with
// BLANK_CYC cycles of all anodes off so the previous digit's segments cannot ghost.
// New data is taken in two steps: load_i latches it as pending, and it is copied to the
// display only at a frame boundary. This keeps a frame from showing a mix of old and new data.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   value_i[15:0]   hex value, [3:0] = digit 0 (rightmost)
//   dp_i[3:0]       decimal-point mask, bit n = digit n
//   load_i          one-cycle strobe capturing value_i/dp_i as pending data
//   blank_lz_i      blank leading zero digits (digit 0 always shown)
//   enable_i        0 = display dark, scan keeps running
//   load_ack_o      one-cycle pulse when pending data is committed
//   sseg_o[7:0]     {dp,g,f,e,d,c,b,a}, registered
//   anodes[3:0]     digit select, bit n = digit n, registered
module sseg_scan_driver #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLANK_CYC  = 16,
  parameter int unsigned SEG_ACT_LO = 1,
  parameter int unsigned AN_ACT_LO  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_i,
  input  logic        load_i,
  input  logic        blank_lz_i,
  input  logic        enable_i,
  output logic        load_ack_o,
  output logic [7:0]  sseg_o,
  output logic [3:0]  anodes
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PresMax = PW'(SCAN_DIV - 1);
  localparam logic [7:0] SegOff = (SEG_ACT_LO != 0) ? 8'hFF : 8'h00;
  localparam logic [3:0] AnOff  = (AN_ACT_LO != 0) ? 4'hF : 4'h0;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] hex_lo(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_val_q, disp_val_d;
  logic [3:0]    disp_dp_q, disp_dp_d;
  logic [15:0]   pend_val_q, pend_val_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          pend_v_q, pend_v_d;
  logic          ack_q, ack_d;
  logic [7:0]    sseg_q, sseg_d;
  logic [3:0]    an_q, an_d;

  logic       tick;
  logic       commit;
  logic       in_gap;
  logic [3:0] digit;
  logic [3:0] lz_vec;
  logic       dig_blank;
  logic [7:0] seg_lo;
  logic [3:0] an_oh;

  always_comb begin
    tick   = (presc_q == PresMax);
    commit = tick && (idx_q == 2'd3) && pend_v_q;
    in_gap = (32'(presc_q) < BLANK_CYC);

    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = tick ? idx_q + 2'd1 : idx_q;

    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_v_d   = pend_v_q;
    ack_d      = commit;
    if (commit) begin
      disp_val_d = pend_val_q;
      disp_dp_d  = pend_dp_q;
      pend_v_d   = 1'b0;
    end
    // A load in the commit cycle becomes the next pending item, not a lost one.
    if (load_i) begin
      pend_val_d = value_i;
      pend_dp_d  = dp_i;
      pend_v_d   = 1'b1;
    end

    unique case (idx_q)
      2'd0:    digit = disp_val_q[3:0];
      2'd1:    digit = disp_val_q[7:4];
      2'd2:    digit = disp_val_q[11:8];
      default: digit = disp_val_q[15:12];
    endcase

    // Digit n is a leading zero when it and every higher digit are zero.
    lz_vec[3] = (disp_val_q[15:12] == 4'h0);
    lz_vec[2] = lz_vec[3] && (disp_val_q[11:8] == 4'h0);
    lz_vec[1] = lz_vec[2] && (disp_val_q[7:4] == 4'h0);
    lz_vec[0] = 1'b0;
    dig_blank = blank_lz_i && lz_vec[idx_q];

    seg_lo[6:0] = dig_blank ? 7'h7F : hex_lo(digit);
    seg_lo[7]   = ~disp_dp_q[idx_q];

    sseg_d = (SEG_ACT_LO != 0) ? seg_lo : ~seg_lo;
    if (!enable_i) sseg_d = SegOff;

    an_oh = 4'b0001 << idx_q;
    if (!enable_i || in_gap) begin
      an_d = AnOff;
    end else begin
      an_d = (AN_ACT_LO != 0) ? ~an_oh : an_oh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      idx_q      <= 2'd0;
      disp_val_q <= 16'h0000;
      disp_dp_q  <= 4'h0;
      pend_val_q <= 16'h0000;
      pend_dp_q  <= 4'h0;
      pend_v_q   <= 1'b0;
      ack_q      <= 1'b0;
      sseg_q     <= SegOff;
      an_q       <= AnOff;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_v_q   <= pend_v_d;
      ack_q      <= ack_d;
      sseg_q     <= sseg_d;
      an_q       <= an_d;
    end
  end

  assign load_ack_o = ack_q;
  assign sseg_o     = sseg_q;
  assign anodes     = an_q;

endmodule
